// File: rtl/adder16_accum_ctrl.sv
// Term accumulator that drives an external 16-bit adder.
// Each packet is summed into acc_reg, with carry-outs counted.
module adder16_accum_ctrl #(
    parameter int CNT_W  = 8,
    parameter int TERM_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    input  logic              in_last,
    output logic [15:0]       add_a,
    output logic [15:0]       add_b,
    input  logic [15:0]       add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_sum,
    output logic [CNT_W-1:0]  out_carries,
    output logic [TERM_W-1:0] out_terms,
    output logic              out_ovf
);

    typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [TERM_W-1:0] TERM_MAX = '1;

    state_t             state;
    state_t             state_nx;
    logic [15:0]        op_reg;
    logic               op_valid;
    logic               op_last;
    logic [15:0]        acc_reg;
    logic [CNT_W-1:0]   carry_cnt;
    logic [TERM_W-1:0]  term_cnt;
    logic               ovf;
    logic               accept;
    logic               add_step;
    logic               out_fire;

    assign accept   = in_valid && in_ready;
    assign add_step = (state == RUN) && op_valid;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:  if (add_step && op_last) state_nx = DONE;
            DONE: if (out_fire) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // in_ready depends only on registers and rst, never on in_valid.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            RUN:  in_ready  = !(op_valid && op_last) && !rst;
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg    <= '0;
            op_valid  <= 1'b0;
            op_last   <= 1'b0;
            acc_reg   <= '0;
            carry_cnt <= '0;
            term_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                op_reg   <= in_data;
                op_last  <= in_last;
                op_valid <= 1'b1;
            end else begin
                op_valid <= 1'b0;
            end

            if (add_step) begin
                acc_reg <= add_sum;
                if (carry_cnt != CNT_MAX) begin
                    carry_cnt <= carry_cnt + {{(CNT_W-1){1'b0}}, add_cout};
                end
                ovf <= ovf | (add_cout && (carry_cnt == CNT_MAX));
                if (term_cnt != TERM_MAX) begin
                    term_cnt <= term_cnt + TERM_W'(1);
                end
            end

            // Results are cleared only once downstream has taken them.
            if (state == DONE && out_fire) begin
                acc_reg   <= '0;
                carry_cnt <= '0;
                term_cnt  <= '0;
                ovf       <= 1'b0;
            end
        end
    end

    assign add_a       = acc_reg;
    assign add_b       = op_reg;
    assign out_sum     = acc_reg;
    assign out_carries = carry_cnt;
    assign out_terms   = term_cnt;
    assign out_ovf     = ovf;

endmodule

// File: tb/tb_adder16_accum_ctrl.sv
// Scoreboard bench: two instances (CNT_W=8 and CNT_W=2) share stimulus,
// each driving its own behavioural 16-bit adder.
module tb_adder16_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready8, out_valid8, add_cout8, out_ovf8;
    logic [15:0] add_a8, add_b8, add_sum8, out_sum8;
    logic [7:0]  out_carries8, out_terms8;

    logic        in_ready2, out_valid2, add_cout2, out_ovf2;
    logic [15:0] add_a2, add_b2, add_sum2, out_sum2;
    logic [1:0]  out_carries2;
    logic [7:0]  out_terms2;

    always #5 clk = ~clk;

    assign {add_cout8, add_sum8} = {1'b0, add_a8} + {1'b0, add_b8};
    assign {add_cout2, add_sum2} = {1'b0, add_a2} + {1'b0, add_b2};

    adder16_accum_ctrl #(.CNT_W(8), .TERM_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_last(in_last), .add_a(add_a8), .add_b(add_b8),
        .add_sum(add_sum8), .add_cout(add_cout8), .out_valid(out_valid8),
        .out_ready(out_ready), .out_sum(out_sum8), .out_carries(out_carries8),
        .out_terms(out_terms8), .out_ovf(out_ovf8)
    );

    adder16_accum_ctrl #(.CNT_W(2), .TERM_W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .add_a(add_a2), .add_b(add_b2),
        .add_sum(add_sum2), .add_cout(add_cout2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .out_carries(out_carries2),
        .out_terms(out_terms2), .out_ovf(out_ovf2)
    );

    typedef struct {
        logic [15:0] sum;
        int          c8;
        int          c2;
        bit          o8;
        bit          o2;
        int          terms;
    } exp_t;

    exp_t    sb[$];
    int      n_checks = 0;
    int      n_fails  = 0;
    int      cyc = 0;
    int      last_acc_cyc = 0;
    longint  m_total = 0;
    int      m_terms = 0;
    bit      chk_pending = 1'b0;
    logic [15:0] chk_a, chk_b;
    bit      prev_ov = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor, operand-stage monitor and latency check.
    always @(negedge clk) begin
        exp_t e;
        if (chk_pending) begin
            check("add_b", add_b8, chk_b);
            check("add_a", add_a8, chk_a);
            chk_pending = 1'b0;
        end
        if (!rst && out_valid8 && !prev_ov) check("latency", cyc - last_acc_cyc, 2);
        prev_ov = out_valid8 && !rst;
        if (!rst && out_valid8 && out_ready) begin
            check("out_valid2", out_valid2, 1);
            if (sb.size() == 0) begin
                check("unexpected_out", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("sum8", out_sum8, e.sum);
                check("carries8", out_carries8, e.c8);
                check("ovf8", out_ovf8, e.o8);
                check("terms8", out_terms8, e.terms);
                check("sum2", out_sum2, e.sum);
                check("carries2", out_carries2, e.c2);
                check("ovf2", out_ovf2, e.o2);
            end
        end
    end

    task automatic send_term(input logic [15:0] d, input bit last);
        bit     done;
        longint c;
        exp_t   e;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                if (last) last_acc_cyc = cyc;
                @(posedge clk); #1;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            check("accept_timeout", 0, 1);
            return;
        end
        chk_b       = d;
        chk_a       = m_total[15:0];
        chk_pending = 1'b1;
        m_total += d;
        m_terms++;
        if (last) begin
            c       = m_total >> 16;
            e.sum   = m_total[15:0];
            e.c8    = (c > 255) ? 255 : int'(c);
            e.o8    = (c > 255);
            e.c2    = (c > 3) ? 3 : int'(c);
            e.o2    = (c > 3);
            e.terms = (m_terms > 255) ? 255 : m_terms;
            sb.push_back(e);
            m_total = 0;
            m_terms = 0;
        end
    endtask

    task automatic wait_drained();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid8) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum"}, out_sum8, 0);
        check({tag, "_carries"}, out_carries8, 0);
        check({tag, "_terms"}, out_terms8, 0);
        check({tag, "_ovf"}, out_ovf8, 0);
        check({tag, "_out_valid"}, out_valid8, 0);
    endtask

    initial begin
        bit seen;
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready8, 0);
        check_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready8, 1);
        @(posedge clk); #1;

        // 1: back-to-back with carry
        out_ready = 1'b1;
        send_term(16'hFFFF, 0);
        send_term(16'h0002, 0);
        send_term(16'h0001, 1);
        wait_drained();

        // 2: single term, downstream stalls
        out_ready = 1'b0;
        send_term(16'h1234, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid8) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("stall_out_valid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid8, 1);
            check("stall_in_ready", in_ready8, 0);
            check("stall_sum", out_sum8, 16'h1234);
            check("stall_carries", out_carries8, 0);
            check("stall_terms", out_terms8, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_hs_in_ready", in_ready8, 1);
        check("post_hs_out_valid", out_valid8, 0);
        @(posedge clk); #1;

        // 3: bubbles between terms
        send_term(16'h0100, 0);
        repeat (2) @(posedge clk); #1;
        send_term(16'h0200, 0);
        repeat (2) @(posedge clk); #1;
        send_term(16'h0300, 1);
        wait_drained();

        // 4: carry saturation on the narrow counter
        for (int i = 0; i < 5; i++) send_term(16'hFFFF, i == 4);
        wait_drained();

        // 5: reset mid-packet
        send_term(16'h8000, 0);
        send_term(16'h8000, 0);
        rst = 1'b1;
        m_total = 0;
        m_terms = 0;
        @(negedge clk);
        check("midrst_in_ready", in_ready8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        check("midrst_carries2", out_carries2, 0);
        @(posedge clk); #1;
        send_term(16'h0005, 1);
        wait_drained();

        // 6: consecutive packets, no carry leakage
        send_term(16'hFFFF, 0);
        send_term(16'h0001, 1);
        send_term(16'h0003, 1);
        wait_drained();

        repeat (3) @(posedge clk);
        check("sb_empty_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
